fifo_drain_ctrl: RTL

Read-side controller for the synchronous FIFO: issues `fifo_rd_en` whenever the FIFO holds data and downstream space exists. It absorbs the FIFO's one-cycle registered read latency and presents words on a valid/ready stream. It sits between the FIFO read port and any consumer, and adds a flush mode that empties the FIFO while discarding the data.

---
 rtl/fifo_drain_pkg.sv | 13 +
 rtl/fifo_rd_skid_buf.sv | 59 +++++
 rtl/fifo_drain_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/fifo_drain_pkg.sv
// Shared types and default widths for the FIFO read-side drain controller.
package fifo_drain_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } drain_state_e;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry in-order buffer catching FIFO read data; entry 0 is always the head.
module fifo_rd_skid_buf #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  input  logic                  clear_i,
  output logic [1:0]            occ_o,
  output logic [DATA_WIDTH-1:0] head_o
);

  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
  logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
  logic                  pop_c;

  assign pop_c  = pop_i && (occ_q != 2'd0);
  assign occ_o  = occ_q;
  assign head_o = ent0_q;

  // Pop shifts entry 1 forward first, so a same-cycle push lands behind any survivor.
  always_comb begin
    occ_d  = occ_q;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    if (clear_i) begin
      occ_d = 2'd0;
    end else begin
      if (pop_c) begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      if (push_i && (occ_d != 2'd2)) begin
        if (occ_d == 2'd0) begin
          ent0_d = push_data_i;
        end else begin
          ent1_d = push_data_i;
        end
        occ_d = occ_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q  <= 2'd0;
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      occ_q  <= occ_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
    end
  end

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side FIFO controller: credit-based reads into a skid buffer feeding a
// valid/ready stream, plus a flush mode that discards the FIFO contents.
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush_req,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  words_out,
  output logic [CNT_WIDTH-1:0]  words_flushed,
  output logic                  flush_done,
  output logic                  busy,
  output logic                  underflow_err
);

  drain_state_e          state_q, state_d;
  logic                  inflight_q;
  logic [CNT_WIDTH-1:0]  words_out_q, words_flushed_q;
  logic                  flush_done_q, flush_done_d;
  logic                  underflow_q;

  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head;
  logic                  accept_c, flush_entry_c, push_c;
  logic [2:0]            used_c;

  assign accept_c      = m_valid && m_ready;
  assign flush_entry_c = flush_req && (state_q != FLUSH);
  assign push_c        = inflight_q && (state_q != FLUSH) && !flush_entry_c;
  // Counting the word leaving this cycle keeps the read pipeline full at 1 word/cycle.
  assign used_c        = 3'(occ) + 3'(inflight_q) - 3'(accept_c);

  fifo_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_c),
    .push_data_i (fifo_data_out),
    .pop_i       (accept_c),
    .clear_i     (flush_entry_c),
    .occ_o       (occ),
    .head_o      (head)
  );

  // Next state and read strobe; a flush request overrides every other transition.
  always_comb begin
    state_d      = state_q;
    fifo_rd_en   = 1'b0;
    flush_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        fifo_rd_en = enable && !fifo_empty && (used_c < 3'd2);
        if (!enable && !inflight_q) state_d = IDLE;
      end
      FLUSH: begin
        fifo_rd_en = !fifo_empty;
        if (fifo_empty && !inflight_q) begin
          state_d      = IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_entry_c) begin
      state_d      = FLUSH;
      flush_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      inflight_q      <= 1'b0;
      words_out_q     <= '0;
      words_flushed_q <= '0;
      flush_done_q    <= 1'b0;
      underflow_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= fifo_rd_en;
      flush_done_q <= flush_done_d;
      if (accept_c) words_out_q <= words_out_q + CNT_WIDTH'(1);
      if ((state_q == FLUSH) && inflight_q) words_flushed_q <= words_flushed_q + CNT_WIDTH'(1);
      if (fifo_underflow) underflow_q <= 1'b1;
    end
  end

  assign m_valid       = (occ != 2'd0);
  assign m_data        = head;
  assign words_out     = words_out_q;
  assign words_flushed = words_flushed_q;
  assign flush_done    = flush_done_q;
  assign busy          = (state_q != IDLE) || inflight_q;
  assign underflow_err = underflow_q;

endmodule
